// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared core types (XLEN, fetch FSM encoding, fetch buffer entry)
// Revision: 1.0
// ============================================================================
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// ============================================================================
// inst_fifo : DEPTH-entry {pc, inst} buffer with push/pop/clear
// Revision: 1.0
// ============================================================================
module inst_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    input  fetch_entry_t           wdata_i,
    output fetch_entry_t           rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != FULL_CNT) || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - (AW + 1)'(1);
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// inst_fetch : single-outstanding instruction fetch with redirect flush
// Revision: 1.0
// ============================================================================
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_en,
    input  logic            redirect,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] req_pc_q;
    logic [XLEN-1:0] req_pc_d;
    logic            push;
    logic            pop;
    logic [CNT_W-1:0] count;
    fetch_entry_t    wdata;
    fetch_entry_t    head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Once issued, a request is held until acked even if a redirect makes it stale.
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        imem_req = 1'b0;
        push     = 1'b0;
        pc_en    = redirect;
        case (state_q)
            IDLE: begin
                if ((count < FULL_CNT) && !redirect) begin
                    req_pc_d = pc;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = IDLE;
                    push    = !redirect;
                    pc_en   = 1'b1;
                end else if (redirect) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr  = req_pc_q;
    assign wdata      = '{pc: req_pc_q, inst: imem_rdata};
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready && !redirect;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (redirect),
        .wdata_i (wdata),
        .rdata_o (head),
        .count_o (count)
    );

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch : directed scenarios plus randomized stream check for inst_fetch
// Revision: 1.0
// ============================================================================
module tb_inst_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic        pc_en;
    logic        redirect = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    always #5 clk = ~clk;

    inst_fetch #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_en      (pc_en),
        .redirect   (redirect),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    // External PC counter: load target on redirect, +4 on pc_en
    logic [31:0] pc_r = '0;
    logic [31:0] target = '0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_load_val = '0;
    assign pc = pc_r;
    always @(posedge clk) begin
        if (pc_load)       pc_r <= pc_load_val;
        else if (redirect) pc_r <= target;
        else if (pc_en)    pc_r <= pc_r + 32'd4;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    int          mem_lat = 0;
    int          mem_cnt = 0;
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] exp_pc = '0;
    logic        s_req, s_pc_en, s_valid;
    logic [31:0] s_addr, s_inst, s_inst_pc;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'h0000_0013;
    endfunction

    // One clock cycle: memory responder, sampling, and in-order stream scoreboard.
    task automatic tick();
        if (imem_req && !mem_busy) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        end
        imem_ack   = mem_busy && (mem_cnt == 0);
        imem_rdata = imem_ack ? memfn(mem_addr) : $urandom;
        @(negedge clk);
        s_req = imem_req; s_pc_en = pc_en; s_valid = inst_valid;
        s_addr = imem_addr; s_inst = inst; s_inst_pc = inst_pc;
        if (mem_busy) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== mem_addr) begin
                n_bad++;
                $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, mem_addr);
            end
        end
        if (inst_valid === 1'b1 && inst_ready && !redirect) begin
            n_cmp++;
            n_acc++;
            if (inst_pc !== exp_pc || inst !== memfn(exp_pc)) begin
                n_bad++;
                $display("FAIL stream: inst_pc=%h inst=%h, required inst_pc=%h inst=%h", inst_pc, inst, exp_pc, memfn(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect) exp_pc = target;
        @(posedge clk);
        if (imem_ack) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        #1;
    endtask

    task automatic do_reset(input logic [31:0] pc0);
        rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
        mem_busy = 1'b0; pc_load = 1'b1; pc_load_val = pc0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pc_load = 1'b0; rst = 1'b0; exp_pc = pc0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc_en !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_req: req=%b addr=%h pc_en=%b, required 0/0/0", imem_req, imem_addr, pc_en);
        end
        n_cmp++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_buf: valid=%b inst=%h inst_pc=%h, required 0/0/0", inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_first_fetch();
        do_reset(32'h0); mem_lat = 0;
        tick();
        n_cmp++;
        if (s_req !== 1'b0) begin n_bad++; $display("FAIL ff_c0_req: req=%b required 0", s_req); end
        tick();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h0 || s_pc_en !== 1'b1) begin
            n_bad++;
            $display("FAIL ff_c1: req=%b addr=%h pc_en=%b, required 1/0/1", s_req, s_addr, s_pc_en);
        end
        tick();
        n_cmp++;
        if (s_valid !== 1'b1 || s_inst_pc !== 32'h0 || s_inst !== 32'h13) begin
            n_bad++;
            $display("FAIL ff_c2: valid=%b inst_pc=%h inst=%h, required 1/0/00000013", s_valid, s_inst_pc, s_inst);
        end
    endtask

    task automatic test_full();
        tick();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h4) begin
            n_bad++; $display("FAIL full_second: req=%b addr=%h, required 1/4", s_req, s_addr);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (s_req !== 1'b0) begin n_bad++; $display("FAIL full_noreq: cycle %0d req=%b required 0", i, s_req); end
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        n_cmp++;
        if (s_req !== 1'b0) begin n_bad++; $display("FAIL full_popcycle: req=%b required 0", s_req); end
        tick();
        n_cmp++;
        if (s_req !== 1'b0) begin n_bad++; $display("FAIL full_sample: req=%b required 0", s_req); end
        tick();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h8) begin
            n_bad++; $display("FAIL full_refetch: req=%b addr=%h, required 1/8", s_req, s_addr);
        end
    endtask

    task automatic test_push_pop();
        do_reset(32'h200); mem_lat = 0;
        tick(); tick(); tick();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tick();
        n_cmp++;
        if (s_valid !== 1'b1 || s_inst_pc !== 32'h204 || s_inst !== memfn(32'h204)) begin
            n_bad++;
            $display("FAIL pushpop_head: valid=%b inst_pc=%h inst=%h, required 1/204/%h", s_valid, s_inst_pc, s_inst, memfn(32'h204));
        end
        tick();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h208) begin
            n_bad++; $display("FAIL pushpop_count: req=%b addr=%h, required 1/208", s_req, s_addr);
        end
    endtask

    task automatic test_redirect_flush();
        int acc0;
        do_reset(32'h0); mem_lat = 3;
        tick(); tick();
        n_cmp++;
        if (s_req !== 1'b1 || s_pc_en !== 1'b0) begin
            n_bad++; $display("FAIL rf_wait: req=%b pc_en=%b, required 1/0", s_req, s_pc_en);
        end
        redirect = 1'b1; target = 32'h100;
        tick();
        redirect = 1'b0;
        n_cmp++;
        if (s_pc_en !== 1'b1) begin n_bad++; $display("FAIL rf_pc_en: pc_en=%b required 1", s_pc_en); end
        tick();
        n_cmp++;
        if (s_req !== 1'b1 || s_pc_en !== 1'b0 || s_addr !== 32'h0) begin
            n_bad++; $display("FAIL rf_flush: req=%b pc_en=%b addr=%h, required 1/0/0", s_req, s_pc_en, s_addr);
        end
        tick();
        n_cmp++;
        if (s_req !== 1'b1 || s_pc_en !== 1'b0) begin
            n_bad++; $display("FAIL rf_ack: req=%b pc_en=%b, required 1/0", s_req, s_pc_en);
        end
        tick();
        n_cmp++;
        if (s_req !== 1'b0 || s_valid !== 1'b0) begin
            n_bad++; $display("FAIL rf_idle: req=%b valid=%b, required 0/0", s_req, s_valid);
        end
        mem_lat = 0;
        tick();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h100 || s_valid !== 1'b0) begin
            n_bad++; $display("FAIL rf_target: req=%b addr=%h valid=%b, required 1/100/0", s_req, s_addr, s_valid);
        end
        acc0 = n_acc;
        inst_ready = 1'b1;
        repeat (6) tick();
        inst_ready = 1'b0;
        n_cmp++;
        if (n_acc - acc0 < 2) begin n_bad++; $display("FAIL rf_progress: accepted=%0d required >=2", n_acc - acc0); end
    endtask

    task automatic test_redirect_ack();
        do_reset(32'h0); mem_lat = 0;
        tick(); tick(); tick();
        redirect = 1'b1; target = 32'h300;
        tick();
        redirect = 1'b0;
        n_cmp++;
        if (s_pc_en !== 1'b1) begin n_bad++; $display("FAIL ra_pc_en: pc_en=%b required 1", s_pc_en); end
        tick();
        n_cmp++;
        if (s_valid !== 1'b0 || s_pc_en !== 1'b0) begin
            n_bad++; $display("FAIL ra_after: valid=%b pc_en=%b, required 0/0", s_valid, s_pc_en);
        end
        inst_ready = 1'b1;
        tick(); tick();
        n_cmp++;
        if (s_valid !== 1'b1 || s_inst_pc !== 32'h300) begin
            n_bad++; $display("FAIL ra_target: valid=%b inst_pc=%h, required 1/300", s_valid, s_inst_pc);
        end
        repeat (4) tick();
        inst_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        do_reset(32'h40); mem_lat = 0;
        tick(); tick();
        mem_lat = 5;
        tick(); tick();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h44) begin
            n_bad++; $display("FAIL rw_wait: req=%b addr=%h, required 1/44", s_req, s_addr);
        end
        imem_ack = 1'b1; imem_rdata = memfn(32'h44);
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || pc_en !== 1'b1 || inst_valid !== 1'b1) begin
            n_bad++; $display("FAIL rw_pre: req=%b pc_en=%b valid=%b, required 1/1/1", imem_req, pc_en, inst_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || pc_en !== 1'b0 || inst_valid !== 1'b0) begin
            n_bad++; $display("FAIL rw_async: req=%b pc_en=%b valid=%b, required 0/0/0", imem_req, pc_en, inst_valid);
        end
        imem_ack = 1'b0; mem_busy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; exp_pc = 32'h44; mem_lat = 0;
        tick(); tick();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h44) begin
            n_bad++; $display("FAIL rw_restart: req=%b addr=%h, required 1/44", s_req, s_addr);
        end
        inst_ready = 1'b1;
        repeat (4) tick();
        inst_ready = 1'b0;
    endtask

    task automatic test_random();
        int          acc0;
        logic [31:0] r;
        r = $urandom;
        do_reset(r & 32'h0000_FFFC);
        mem_lat = -1;
        acc0 = n_acc;
        for (int i = 0; i < 3000; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect   = ($urandom_range(0, 19) == 0);
            r = $urandom;
            target = r & 32'h000F_FFFC;
            tick();
        end
        redirect = 1'b0; inst_ready = 1'b0;
        n_cmp++;
        if (n_acc - acc0 < 100) begin
            n_bad++; $display("FAIL rand_progress: accepted=%0d required >=100", n_acc - acc0);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_full();
        test_push_pop();
        test_redirect_flush();
        test_redirect_ack();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
